// File: rtl/prng_lfsr_gen_pkg.sv
// Shared constants and the single-step Fibonacci feedback used by the LFSR generator.
// Functions work on 64-bit containers so one definition serves every legal width.
package prng_pkg;

    localparam int MAX_WIDTH = 64;

    // Maximal-length tap masks for common widths (bit k set = stage k feeds the XOR)
    localparam logic [3:0]  TAPS_W4  = 4'hC;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

    function automatic logic [MAX_WIDTH-1:0] lfsr_step(
        input logic [MAX_WIDTH-1:0] state,
        input logic [MAX_WIDTH-1:0] taps,
        input int                   width
    );
        logic [MAX_WIDTH-1:0] mask;
        logic                 fb;
        mask = (64'h1 << width) - 64'h1;
        fb   = ^(state & taps);
        return ((state << 1) | {{(MAX_WIDTH-1){1'b0}}, fb}) & mask;
    endfunction

endpackage

// File: rtl/prng_lfsr_gen_stepper.sv
// Combinational unroll of STEPS Fibonacci LFSR steps; the state shifts toward the MSB
// and the feedback bit enters at bit 0.
module lfsr_stepper #(
    parameter int WIDTH = 16,
    parameter int STEPS = 4
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] next_state
);
    import prng_pkg::*;

    logic [WIDTH-1:0] work;

    always_comb begin
        work = state;
        for (int i = 0; i < STEPS; i++) begin
            work = WIDTH'(lfsr_step(64'(work), 64'(taps), WIDTH));
        end
        next_state = work;
    end

endmodule

// File: rtl/prng_lfsr_gen.sv
// Parametrised LFSR word generator: OUT_W fresh bits per word, runtime seed loading
// with zero-seed substitution, valid/ready output and a period-wrap flag.
module prng_lfsr_gen #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter int               OUT_W = 4,
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             preset,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             wrap,
    output logic             seed_fixup
);
    import prng_pkg::*;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] start_state;
    logic [WIDTH-1:0] adv_state;
    logic [WIDTH-1:0] load_value;
    logic [OUT_W-1:0] word;
    logic             seed_is_zero;
    logic             produce;

    lfsr_stepper #(
        .WIDTH (WIDTH),
        .STEPS (OUT_W)
    ) u_stepper (
        .state      (s),
        .taps       (TAPS),
        .next_state (adv_state)
    );

    // The word is read MSB-first from the state before it advances
    always_comb begin
        word = '0;
        for (int j = 0; j < OUT_W; j++) begin
            word[j] = s[WIDTH-1-j];
        end
    end

    always_comb begin
        seed_is_zero = (seed_in == '0);
        load_value   = seed_is_zero ? SEED : seed_in;
        produce      = en && (!dout_valid || dout_ready) && !seed_load;
    end

    // A load flushes any pending word and outranks production and consumption
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            s           <= SEED;
            start_state <= SEED;
            dout        <= '0;
            dout_valid  <= 1'b0;
            wrap        <= 1'b0;
            seed_fixup  <= 1'b0;
        end else if (seed_load) begin
            s           <= load_value;
            start_state <= load_value;
            dout_valid  <= 1'b0;
            wrap        <= 1'b0;
            seed_fixup  <= seed_is_zero;
        end else begin
            seed_fixup <= 1'b0;
            if (produce) begin
                dout       <= word;
                dout_valid <= 1'b1;
                s          <= adv_state;
                wrap       <= (adv_state == start_state);
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
                wrap       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prng_lfsr_gen.sv
// Directed bench for prng_lfsr_gen: default 16-bit instance plus a 4-bit, 1-bit-word
// instance whose full 15-state period is tabulated by hand.
module tb_prng_lfsr_gen;

    logic        clk = 1'b0;
    logic        preset, en, seed_load, dout_ready;
    logic [15:0] seed_in;
    logic [3:0]  dout;
    logic        dout_valid, wrap, seed_fixup;

    logic        preset_b, en_b, seed_load_b, dout_ready_b;
    logic [3:0]  seed_in_b;
    logic        dout_b, dout_valid_b, wrap_b, seed_fixup_b;

    int total = 0;
    int bad   = 0;

    // Bench-side expectation of the default instance
    logic [15:0] m_s, m_start;
    logic [3:0]  m_dout;
    logic        m_valid, m_wrap, m_fix;
    logic [15:0] ref_next;

    logic [6:0] obs_a;
    logic [6:0] exp_a;
    assign obs_a = {dout, dout_valid, wrap, seed_fixup};
    assign exp_a = {m_dout, m_valid, m_wrap, m_fix};

    always #5 clk = ~clk;

    prng_lfsr_gen u_dut (
        .clk        (clk),
        .preset     (preset),
        .en         (en),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .wrap       (wrap),
        .seed_fixup (seed_fixup)
    );

    prng_lfsr_gen #(
        .WIDTH (4),
        .TAPS  (4'hC),
        .OUT_W (1),
        .SEED  (4'h1)
    ) u_dut_b (
        .clk        (clk),
        .preset     (preset_b),
        .en         (en_b),
        .seed_load  (seed_load_b),
        .seed_in    (seed_in_b),
        .dout       (dout_b),
        .dout_valid (dout_valid_b),
        .dout_ready (dout_ready_b),
        .wrap       (wrap_b),
        .seed_fixup (seed_fixup_b)
    );

    lfsr_stepper #(
        .WIDTH (16),
        .STEPS (4)
    ) u_ref (
        .state      (m_s),
        .taps       (16'hB400),
        .next_state (ref_next)
    );

    // x^16+x^14+x^13+x^11+1 written out bit by bit
    function automatic logic [15:0] ref_step1(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] ref_adv(input logic [15:0] s);
        return ref_step1(ref_step1(ref_step1(ref_step1(s))));
    endfunction

    function automatic logic [3:0] ref_word(input logic [15:0] s);
        return {s[12], s[13], s[14], s[15]};
    endfunction

    task automatic model_reset();
        m_s     = 16'hFFFF;
        m_start = 16'hFFFF;
        m_dout  = 4'h0;
        m_valid = 1'b0;
        m_wrap  = 1'b0;
        m_fix   = 1'b0;
    endtask

    task automatic model_tick();
        logic [15:0] v;
        if (seed_load) begin
            v       = (seed_in == 16'h0) ? 16'hFFFF : seed_in;
            m_s     = v;
            m_start = v;
            m_valid = 1'b0;
            m_wrap  = 1'b0;
            m_fix   = (seed_in == 16'h0);
        end else begin
            m_fix = 1'b0;
            if (en && (!m_valid || dout_ready)) begin
                m_dout  = ref_word(m_s);
                m_s     = ref_adv(m_s);
                m_valid = 1'b1;
                m_wrap  = (m_s == m_start);
            end else if (m_valid && dout_ready) begin
                m_valid = 1'b0;
                m_wrap  = 1'b0;
            end
        end
    endtask

    task automatic tick_a();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if (obs_a !== 7'h00) begin
            bad++;
            $display("[TB] FAIL reset_a: got %h expected %h", obs_a, 7'h00);
        end
        total++;
        if ({dout_b, dout_valid_b, wrap_b, seed_fixup_b} !== 4'h0) begin
            bad++;
            $display("[TB] FAIL reset_b: got %h expected %h",
                     {dout_b, dout_valid_b, wrap_b, seed_fixup_b}, 4'h0);
        end
        model_reset();
    endtask

    task automatic test_first_words();
        preset     = 1'b0;
        en         = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_a();
            total++;
            if (obs_a !== {4'hF, 3'b100}) begin
                bad++;
                $display("[TB] FAIL first_word%0d: got %h expected %h", i, obs_a, {4'hF, 3'b100});
            end
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 1000; i++) begin
            dout_ready = (i % 7 != 3);
            en         = (i % 11 != 5);
            tick_a();
            total++;
            if (obs_a !== exp_a) begin
                bad++;
                $display("[TB] FAIL stream%0d: got %h expected %h", i, obs_a, exp_a);
            end
            total++;
            if (ref_next !== ref_adv(m_s)) begin
                bad++;
                $display("[TB] FAIL stepper%0d: got %h expected %h", i, ref_next, ref_adv(m_s));
            end
        end
        en         = 1'b1;
        dout_ready = 1'b1;
    endtask

    task automatic test_backpressure();
        tick_a();
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_a();
            total++;
            if (obs_a !== exp_a || dout_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL hold%0d: got %h expected %h", i, obs_a, exp_a);
            end
        end
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick_a();
            total++;
            if (obs_a !== exp_a) begin
                bad++;
                $display("[TB] FAIL resume%0d: got %h expected %h", i, obs_a, exp_a);
            end
        end
    endtask

    task automatic test_seed_zero();
        seed_load = 1'b1;
        seed_in   = 16'h0000;
        tick_a();
        seed_load = 1'b0;
        total++;
        if ({dout_valid, wrap, seed_fixup} !== 3'b001) begin
            bad++;
            $display("[TB] FAIL zero_load: got %b expected %b", {dout_valid, wrap, seed_fixup}, 3'b001);
        end
        for (int i = 0; i < 3; i++) begin
            tick_a();
            total++;
            if (obs_a !== {4'hF, 3'b100}) begin
                bad++;
                $display("[TB] FAIL zero_word%0d: got %h expected %h", i, obs_a, {4'hF, 3'b100});
            end
        end
    endtask

    task automatic test_load_vs_ready();
        tick_a();
        seed_load = 1'b1;
        seed_in   = 16'h0001;
        tick_a();
        seed_load = 1'b0;
        total++;
        if ({dout_valid, wrap, seed_fixup} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL load_wins: got %b expected %b", {dout_valid, wrap, seed_fixup}, 3'b000);
        end
        tick_a();
        total++;
        if (obs_a !== {4'h0, 3'b100}) begin
            bad++;
            $display("[TB] FAIL load_word: got %h expected %h", obs_a, {4'h0, 3'b100});
        end
        tick_a();
        total++;
        if (obs_a !== exp_a) begin
            bad++;
            $display("[TB] FAIL load_next: got %h expected %h", obs_a, exp_a);
        end
    endtask

    task automatic test_en_fall();
        en         = 1'b0;
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_a();
            total++;
            if (obs_a !== exp_a || dout_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL en_hold%0d: got %h expected %h", i, obs_a, exp_a);
            end
        end
        dout_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick_a();
            total++;
            if (obs_a !== exp_a || dout_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL en_drain%0d: got %h expected %h", i, obs_a, exp_a);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_async_preset();
        for (int i = 0; i < 3; i++) tick_a();
        #2;
        preset = 1'b1;
        #1;
        total++;
        if (obs_a !== 7'h00) begin
            bad++;
            $display("[TB] FAIL async_clear: got %h expected %h", obs_a, 7'h00);
        end
        model_reset();
        #2;
        preset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_a();
            total++;
            if (obs_a !== {4'hF, 3'b100}) begin
                bad++;
                $display("[TB] FAIL restart%0d: got %h expected %h", i, obs_a, {4'hF, 3'b100});
            end
        end
    endtask

    task automatic test_wrap_small();
        logic [14:0] tbl;
        tbl          = 15'b111101011001000;
        preset_b     = 1'b0;
        en_b         = 1'b1;
        dout_ready_b = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            total++;
            if ({dout_b, dout_valid_b, wrap_b, seed_fixup_b} !==
                {tbl[(k-1) % 15], 1'b1, (k % 15 == 0), 1'b0}) begin
                bad++;
                $display("[TB] FAIL small_word%0d: got %b expected %b", k,
                         {dout_b, dout_valid_b, wrap_b, seed_fixup_b},
                         {tbl[(k-1) % 15], 1'b1, (k % 15 == 0), 1'b0});
            end
        end
    endtask

    initial begin
        preset       = 1'b1;
        en           = 1'b0;
        seed_load    = 1'b0;
        seed_in      = 16'h0;
        dout_ready   = 1'b0;
        preset_b     = 1'b1;
        en_b         = 1'b0;
        seed_load_b  = 1'b0;
        seed_in_b    = 4'h0;
        dout_ready_b = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_first_words();
        test_stream();
        test_backpressure();
        test_seed_zero();
        test_load_vs_ready();
        test_en_fall();
        test_async_preset();
        test_wrap_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prng_lfsr_gen.md
# prng_lfsr_gen

Parametrised Fibonacci LFSR pseudo-random word generator, the successor of the fixed 16-bit, 4-bit-output generator. Width, tap polynomial, output word width and reset seed are parameters. The block advances the register OUT_W steps per emitted word so every word carries fresh bits. It adds runtime seed loading with zero-seed protection, a valid/ready output handshake and a period-wrap indicator. It sits between the system clock domain and any consumer of random codes (pattern/stimulus logic, game or display logic).

## Interface
- WIDTH, 16: LFSR length in bits, 3..64.
- TAPS, 16'hB400: feedback mask; bit k set means stage k feeds the XOR (default = x^16+x^14+x^13+x^11+1).
- OUT_W, 4: output word width and steps per word, 1..WIDTH.
- SEED, all ones: preset state and zero-seed substitute; must be nonzero.
- clk  in  1  system clock, rising edge.
- preset  in  1  asynchronous, active-high reset.
- en  in  1  generation enable; when low, no word is produced and state holds.
- seed_load  in  1  single-cycle request to load seed_in.
- seed_in  in  WIDTH  new seed value.
- dout  out  OUT_W  random word.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout this cycle.
- wrap  out  1  qualifies dout: this word completes one full period from the start state.
- seed_fixup  out  1  one-cycle pulse: a zero seed was replaced by SEED.

## Operation
- State s[WIDTH-1:0]. One step: f = ^(s & TAPS); s <= {s[WIDTH-2:0], f}.
- Word extraction from the current state: dout[j] = s[WIDTH-1-j] for j = 0..OUT_W-1.
- start_state register holds the last loaded seed (SEED after preset).
- Produce condition: en && (!dout_valid || dout_ready) && !seed_load.
- On produce:
  - dout <= extracted word; dout_valid <= 1.
  - s <= state after OUT_W steps (unrolled, combinational, one cycle).
  - wrap <= (advanced state == start_state).
- Consume without produce (dout_valid && dout_ready && !(en)): dout_valid <= 0; wrap <= 0.
- seed_load, which has priority over everything except preset:
  - v = (seed_in == 0) ? SEED : seed_in.
  - s <= v; start_state <= v.
  - dout_valid <= 0 and wrap <= 0, flushing the stale word.
  - seed_fixup <= (seed_in == 0).
- seed_fixup is 0 in every cycle without a zero-seed load.
- The all-zero state is unreachable: preset and load never install zero.

## Timing
- preset asserted: s = SEED, start_state = SEED, dout = 0, dout_valid = 0, wrap = 0, seed_fixup = 0. This takes effect immediately, mid-operation included.
- First word: dout_valid rises on the first clk edge after preset deasserts with en = 1.
- With dout_ready held high and en high, one new word is produced every cycle, with no bubbles.
- dout_ready low with dout_valid high: dout, wrap and s hold stable until accepted.
- seed_load: the next word comes from the new seed, dout_valid is low for exactly one cycle, and seed_fixup is registered in the same cycle as the load.
- seed_load and dout_ready in the same cycle: the load wins and the pending word is dropped.
- en falling while dout_valid is high: the word stays presented until accepted, and no new word follows.

## Structure
- Package prng_pkg:
  - Default tap constants per width: 4, 8, 16, 32.
  - Function lfsr_step(state, taps) for the single-step feedback.
- Sub-module lfsr_stepper (combinational): inputs state and TAPS, parameter STEPS = OUT_W; produces the advanced state. It is reused by the bench as a reference model.
- Top-level prng_lfsr_gen holds the state register, start_state, the output register and the handshake logic.

## Test plan
- Default params, preset pulse, en = 1, ready = 1 → 3 consecutive words all 4'hF (state FFFF→FFF0→FF00). Words then match the lfsr_stepper model for 1000 cycles.
- WIDTH = 4, TAPS = 4'hC, OUT_W = 1, SEED = 4'h1 → states 1, 2, 4, 9, 3, 6, …; dout = 0, 0, 0, 1, 0, …; wrap = 1 on exactly the 15th word and every 15th after.
- seed_load with seed_in = 0 → seed_fixup pulses once, dout_valid low one cycle, next word equals the post-preset first word.
- dout_ready held low 5 cycles mid-stream → dout and dout_valid stable; the stream resumes with no skipped or repeated word versus the model.
- preset asserted asynchronously between clock edges mid-stream → outputs clear immediately; the sequence restarts from SEED.
- seed_load and dout_ready in the same cycle with seed_in = 16'h0001 → pending word dropped; the next word is 4'h0 with seed_fixup = 0.
